// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider with valid/ready handshakes
// on both the operand and result sides.
// Default build divides unsigned operands; defining SEQ_DIVIDER_SIGNED_EN
// switches to two's-complement operands with truncation toward zero.
// A zero divisor bypasses the iteration and reports quotient = all ones,
// remainder = dividend and div_by_zero = 1.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Counter must be able to hold WIDTH itself: CALC exits once it sees WIDTH.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;       // dividend magnitude shifts out, quotient bits shift in
    logic [WIDTH-1:0] part_rem;  // partial remainder
    logic [WIDTH-1:0] dvs;       // divisor magnitude
    logic [CW-1:0]    iter;      // completed iterations
    logic             neg_q;     // quotient must be negated in FIX
    logic             neg_r;     // remainder must be negated in FIX

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operand magnitudes and signs; the unsigned build ties the signs low so the
    // FIX correction degenerates to a plain copy.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        dividend_neg = dividend[WIDTH-1];
        divisor_neg  = divisor[WIDTH-1];
        // -MIN wraps back to MIN, which read unsigned is exactly |MIN|.
        dividend_mag = dividend_neg ? -dividend : dividend;
        divisor_mag  = divisor_neg  ? -divisor  : divisor;
`else
        dividend_neg = 1'b0;
        divisor_neg  = 1'b0;
        dividend_mag = dividend;
        divisor_mag  = divisor;
`endif
    end

    // One restoring step: shift the next dividend bit into the partial remainder
    // and trial-subtract the divisor. part_rem < dvs keeps shifted below
    // 2*dvs, so the MSB of trial is a clean borrow flag.
    always_comb begin
        shifted = {part_rem, acc[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    // Control FSM and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            part_rem    <= '0;
            dvs         <= '0;
            iter        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            acc      <= dividend_mag;
                            dvs      <= divisor_mag;
                            part_rem <= '0;
                            iter     <= '0;
                            neg_q    <= dividend_neg ^ divisor_neg;
                            neg_r    <= dividend_neg;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (iter == CW'(WIDTH)) begin
                        state <= FIX;
                    end else begin
                        if (!trial[WIDTH]) begin
                            part_rem <= trial[WIDTH-1:0];
                            acc      <= {acc[WIDTH-2:0], 1'b1};
                        end else begin
                            part_rem <= shifted[WIDTH-1:0];
                            acc      <= {acc[WIDTH-2:0], 1'b0};
                        end
                        iter <= iter + CW'(1);
                    end
                end
                FIX: begin
                    quotient    <= neg_q ? -acc : acc;
                    remainder   <= neg_r ? -part_rem : part_rem;
                    div_by_zero <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors for seq_divider (WIDTH = 8) with expected
// values worked out by hand for both the unsigned and the signed build.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Counts edges after the accepting edge until out_valid is seen (0 = high
    // right after the accepting edge). Caller is #1 past the accepting edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Present one operand pair, check latency and result, then drain it.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_q, input logic [7:0] exp_r,
                           input logic exp_dbz, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = 8'h33;
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_q"}, 32'(quotient), 32'(exp_q));
        check({tag, "_r"}, 32'(remainder), 32'(exp_r));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'h00;
        divisor   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Mode-independent vectors.
        run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10);
        run_div("div0",   8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 0);
        run_div("d7_9",   8'h07, 8'h09, 8'h00, 8'h07, 1'b0, 10);
        run_div("dff_01", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 10);
        run_div("dff_ff", 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 10);
`ifdef SEQ_DIVIDER_SIGNED_EN
        run_div("df9_02", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10);
        run_div("min_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10);
        run_div("d64_f9", 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 10);
`else
        run_div("df9_02", 8'hF9, 8'h02, 8'h7C, 8'h01, 1'b0, 10);
        run_div("d80_ff", 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 10);
        run_div("d64_f9", 8'h64, 8'hF9, 8'h00, 8'h64, 1'b0, 10);
`endif

        // Backpressure: hold the result for 5 cycles while in_valid toggles.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0];
            dividend = 8'h11;
            divisor  = 8'h03;
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_q", 32'(quotient), 32'd14);
            check("bp_r", 32'(remainder), 32'd2);
            check("bp_dbz", 32'(div_by_zero), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp_idle_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of CALC, after the fourth iteration.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_q", 32'(quotient), 32'd0);
        check("midrst_r", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("post_rst", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port in_valid  input  1  operand pair valid.
REQ-005 SHALL provide port in_ready  output  1  block can accept operands.
REQ-006 SHALL provide port dividend  input  WIDTH  numerator.
REQ-007 SHALL provide port divisor  input  WIDTH  denominator.
REQ-008 SHALL provide port out_valid  output  1  result valid.
REQ-009 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-010 SHALL provide port quotient  output  WIDTH  quotient.
REQ-011 SHALL provide port remainder  output  WIDTH  remainder.
REQ-012 SHALL provide port div_by_zero  output  1  result came from a zero divisor.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-014 SHALL accept operands on an edge where in_valid && in_ready, registering dividend/divisor; inputs are ignored in any other state.
REQ-015 SHALL, with nonzero divisor, go IDLE->CALC on acceptance, and perform one radix-2 restoring iteration per edge in CALC (shift partial remainder left, trial subtract divisor magnitude, set quotient bit on non-negative) for exactly WIDTH edges, tracked by an iteration counter.
REQ-016 SHALL spend one edge in FIX applying sign correction, then enter DONE; out_valid is therefore high after edge WIDTH+2 counted from the accepting edge (edge 0).
REQ-017 SHALL, with divisor == 0, go IDLE->DONE on the accepting edge +1: quotient = all ones, remainder = dividend, div_by_zero = 1; CALC/FIX skipped.
REQ-018 SHALL hold quotient, remainder, div_by_zero stable while out_valid && !out_ready.
REQ-019 SHALL leave DONE for IDLE on the edge where out_valid && out_ready; no new operand is accepted on that same edge (in_ready is high from the following cycle).
REQ-020 SHALL keep div_by_zero = 0 for every nonzero-divisor result.
REQ-021 SHALL satisfy dividend == quotient*divisor + remainder with |remainder| < |divisor| for every nonzero-divisor result, in the active arithmetic mode.

Reset
REQ-022 SHALL, when rst is high at an edge, enter IDLE regardless of state (including mid-CALC/FIX/DONE), discarding any operation in progress.
REQ-023 SHALL reset quotient, remainder, div_by_zero, iteration counter and internal operand registers to 0; out_valid reads 0 and in_ready reads 1 after the reset edge.

Configuration
REQ-024 SHALL honour macro SEQ_DIVIDER_SIGNED_EN.
REQ-025 SHALL, with SEQ_DIVIDER_SIGNED_EN defined, treat operands as two's complement: divide magnitudes, negate quotient in FIX when operand signs differ, remainder takes dividend's sign (truncation toward zero); MIN / -1 yields quotient = MIN, remainder = 0, div_by_zero = 0.
REQ-026 SHALL, without SEQ_DIVIDER_SIGNED_EN, treat operands as unsigned; FIX still consumes one edge but applies no correction, so latency is unchanged.

Verification
REQ-027 SHALL cover WIDTH=8, 100/7 (either mode) -> quotient 14, remainder 2, div_by_zero 0, out_valid first high 10 edges after accept.
REQ-028 SHALL cover signed: 0xF9 (-7) / 0x02 -> quotient 0xFD (-3), remainder 0xFF (-1); unsigned: 0xF9/0x02 -> quotient 0x7C, remainder 0x01.
REQ-029 SHALL cover 0x55 / 0x00 -> out_valid one edge after accept, quotient 0xFF, remainder 0x55, div_by_zero 1.
REQ-030 SHALL cover signed 0x80 / 0xFF -> quotient 0x80, remainder 0x00, div_by_zero 0.
REQ-031 SHALL cover backpressure: out_ready low 5 cycles in DONE with in_valid toggling -> outputs stable, in_ready 0, no operand captured; out_ready high -> IDLE next edge, in_ready 1.
REQ-032 SHALL cover rst high at iteration 4 of CALC -> next cycle out_valid 0, in_ready 1, quotient/remainder/div_by_zero 0; a fresh 100/7 then completes correctly.
